// File: rtl/mib_arb_pkg.sv
// rtl/mib_arb_pkg.sv - shared types and helpers for the MIB port arbiter
// Contents: arbiter FSM state enum, clog2 helper, default tag address width,
// request payload struct at the default MIB widths.
package mib_arb_pkg;

   typedef enum logic {
      ARB  = 1'b0,
      HOLD = 1'b1
   } arb_state_t;

   // Minimum result of 1 so a 2-entry index still gets a real bit.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   localparam int DEF_TAG_DEPTH = 8;
   localparam int TAG_AW        = clog2(DEF_TAG_DEPTH);

   localparam int MIB_ADDR_W = 36;
   localparam int MIB_DATA_W = 128;

   typedef struct packed {
      logic                      rnw;
      logic [MIB_ADDR_W-1:0]     addr;
      logic [MIB_DATA_W/8-1:0]   be;
      logic [MIB_DATA_W-1:0]     wdata;
   } mib_req_t;

endpackage

// File: rtl/mib_tag_fifo.sv
// rtl/mib_tag_fifo.sv - port-ID tag FIFO for in-order read-return routing
// Ports: clk, rst_n (async active-low), push/push_data, pop, head (current
// oldest entry), full, empty. Push and pop in the same cycle both take effect.
module mib_tag_fifo
   import mib_arb_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int DEPTH = DEF_TAG_DEPTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot, so a full FIFO may still push.
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage needs no reset: only entries between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/mib_port_arbiter.sv
// rtl/mib_port_arbiter.sv - round-robin merge of NUM_PORTS masters onto one MIB port
// Ports: mc_mibclk / mi_mcreset_n (async active-low); per-port request
// p_req_valid/ready/rnw/addr/be/wdata (flattened, port 0 in LSBs); per-port
// read return p_rd_valid/err with shared p_rd_data; controller command
// mi_mc* outputs, mc_miaddrreadytoaccept and mc_mireaddata* inputs.
// Optional macro MIB_ARB_CONFLICT_HINT_EN enables the open-row conflict hints.
module mib_port_arbiter
   import mib_arb_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int ADDR_W    = 36,
   parameter int DATA_W    = 128,
   parameter int TAG_DEPTH = 8,
   parameter int BANK_LSB  = 12,
   parameter int ROW_LSB   = 14,
   localparam int BE_W     = DATA_W / 8
) (
   input  logic                          mc_mibclk,
   input  logic                          mi_mcreset_n,
   input  logic [NUM_PORTS-1:0]          p_req_valid,
   output logic [NUM_PORTS-1:0]          p_req_ready,
   input  logic [NUM_PORTS-1:0]          p_req_rnw,
   input  logic [NUM_PORTS*ADDR_W-1:0]   p_req_addr,
   input  logic [NUM_PORTS*BE_W-1:0]     p_req_be,
   input  logic [NUM_PORTS*DATA_W-1:0]   p_req_wdata,
   output logic [NUM_PORTS-1:0]          p_rd_valid,
   output logic [NUM_PORTS-1:0]          p_rd_err,
   output logic [DATA_W-1:0]             p_rd_data,
   output logic                          mi_mcaddressvalid,
   output logic                          mi_mcreadnotwrite,
   output logic                          mi_mcwritedatavalid,
   output logic [ADDR_W-1:0]             mi_mcaddress,
   output logic [BE_W-1:0]               mi_mcbyteenable,
   output logic [DATA_W-1:0]             mi_mcwritedata,
   output logic                          mi_mcbankconflict,
   output logic                          mi_mcrowconflict,
   input  logic                          mc_miaddrreadytoaccept,
   input  logic [DATA_W-1:0]             mc_mireaddata,
   input  logic                          mc_mireaddatavalid,
   input  logic                          mc_mireaddataerr
);

   localparam int PW = clog2(NUM_PORTS);

   arb_state_t             state;
   arb_state_t             state_nxt;
   logic [PW-1:0]          rr_ptr;
   logic [PW-1:0]          pick;
   logic                   found;
   logic                   grant;
   logic                   tag_push;
   logic [NUM_PORTS-1:0]   eligible;
   int                     idx;

   logic                   cmd_rnw;
   logic [ADDR_W-1:0]      cmd_addr;
   logic [BE_W-1:0]        cmd_be;
   logic [DATA_W-1:0]      cmd_wdata;
   logic [PW-1:0]          cmd_port;

   logic [PW-1:0]          tag_head;
   logic                   tag_full;
   logic                   tag_empty;
   logic                   rd_orphan_err;

   // Reads need a free tag slot at issue time; writes never consume one.
   assign eligible = p_req_valid & ~(p_req_rnw & {NUM_PORTS{tag_full}});

   // First eligible port at or after the round-robin pointer.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         idx = (int'(rr_ptr) + i) % NUM_PORTS;
         if (!found && eligible[idx]) begin
            found = 1'b1;
            pick  = PW'(idx);
         end
      end
   end

   always_ff @(posedge mc_mibclk or negedge mi_mcreset_n) begin
      if (!mi_mcreset_n) state <= ARB;
      else               state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      grant       = 1'b0;
      tag_push    = 1'b0;
      p_req_ready = '0;
      case (state)
         ARB: begin
            if (found) begin
               grant             = 1'b1;
               p_req_ready[pick] = 1'b1;
               state_nxt         = HOLD;
            end
         end
         HOLD: begin
            if (mc_miaddrreadytoaccept) begin
               tag_push  = cmd_rnw;
               state_nxt = ARB;
            end
         end
         default: state_nxt = ARB;
      endcase
   end

   // Command register: loaded on grant, held untouched through HOLD.
   always_ff @(posedge mc_mibclk or negedge mi_mcreset_n) begin
      if (!mi_mcreset_n) begin
         rr_ptr    <= '0;
         cmd_rnw   <= 1'b0;
         cmd_addr  <= '0;
         cmd_be    <= '0;
         cmd_wdata <= '0;
         cmd_port  <= '0;
      end else if (grant) begin
         rr_ptr    <= (pick == PW'(NUM_PORTS - 1)) ? '0 : pick + 1'b1;
         cmd_rnw   <= p_req_rnw[pick];
         cmd_addr  <= p_req_addr[pick*ADDR_W +: ADDR_W];
         cmd_be    <= p_req_be[pick*BE_W +: BE_W];
         cmd_wdata <= p_req_wdata[pick*DATA_W +: DATA_W];
         cmd_port  <= pick;
      end
   end

   assign mi_mcaddressvalid   = (state == HOLD);
   assign mi_mcwritedatavalid = (state == HOLD) & ~cmd_rnw;
   assign mi_mcreadnotwrite   = cmd_rnw;
   assign mi_mcaddress        = cmd_addr;
   assign mi_mcbyteenable     = cmd_be;
   assign mi_mcwritedata      = cmd_wdata;

   mib_tag_fifo #(
      .WIDTH (PW),
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk       (mc_mibclk),
      .rst_n     (mi_mcreset_n),
      .push      (tag_push),
      .push_data (cmd_port),
      .pop       (mc_mireaddatavalid),
      .head      (tag_head),
      .full      (tag_full),
      .empty     (tag_empty)
   );

   // Read return: one registered stage, routed to the oldest outstanding tag.
   always_ff @(posedge mc_mibclk or negedge mi_mcreset_n) begin
      if (!mi_mcreset_n) begin
         p_rd_valid    <= '0;
         p_rd_err      <= '0;
         p_rd_data     <= '0;
         rd_orphan_err <= 1'b0;
      end else begin
         p_rd_valid <= '0;
         p_rd_err   <= '0;
         if (mc_mireaddatavalid) begin
            if (tag_empty) begin
               rd_orphan_err <= 1'b1;
            end else begin
               p_rd_valid[tag_head] <= 1'b1;
               p_rd_err[tag_head]   <= mc_mireaddataerr;
               p_rd_data            <= mc_mireaddata;
            end
         end
      end
   end

   // Read data with no outstanding tag means the controller and arbiter disagree.
   a_no_orphan_read: assert property (
      @(posedge mc_mibclk) disable iff (!mi_mcreset_n) !rd_orphan_err);

`ifdef MIB_ARB_CONFLICT_HINT_EN
   logic [3:0]  row_vld;
   logic [12:0] row_tab [4];
   logic [1:0]  cmd_bank;
   logic [12:0] cmd_row;

   assign cmd_bank = cmd_addr[BANK_LSB +: 2];
   assign cmd_row  = cmd_addr[ROW_LSB +: 13];

   always_ff @(posedge mc_mibclk or negedge mi_mcreset_n) begin
      if (!mi_mcreset_n) begin
         row_vld <= '0;
         for (int b = 0; b < 4; b++) row_tab[b] <= '0;
      end else if ((state == HOLD) && mc_miaddrreadytoaccept) begin
         row_vld[cmd_bank] <= 1'b1;
         row_tab[cmd_bank] <= cmd_row;
      end
   end

   assign mi_mcbankconflict = (state == HOLD) & row_vld[cmd_bank] &
                              (row_tab[cmd_bank] != cmd_row);
   assign mi_mcrowconflict  = (state == HOLD) & row_vld[cmd_bank] &
                              (row_tab[cmd_bank] == cmd_row);
`else
   logic unused_cfg;
   assign unused_cfg        = ^{BANK_LSB, ROW_LSB};
   assign mi_mcbankconflict = 1'b0;
   assign mi_mcrowconflict  = 1'b0;
`endif

endmodule

// File: doc/mib_port_arbiter.md
Name: mib_port_arbiter

Overview:
- N-port front-end that merges several master request streams onto the single MIB command/data interface of the DDR2 memory controller.
- Round-robin arbitration, registered command issue stage, in-order read-return routing via a port-ID tag FIFO.
- Sits between PLB/crossbar masters and the DDR2 controller MIB ports; generalises the single-master MIB attachment to NUM_PORTS.

Parameters:
- NUM_PORTS, 2, number of master ports (2..8).
- ADDR_W, 36, MIB address width.
- DATA_W, 128, data width; BE_W = DATA_W/8.
- TAG_DEPTH, 8, outstanding reads (power of 2, >=2).
- BANK_LSB, 12, LSB of 2-bit bank field in address (optional feature only).
- ROW_LSB, 14, LSB of 13-bit row field in address (optional feature only).

Ports:
- mc_mibclk  in  1  sole clock.
- mi_mcreset_n  in  1  asynchronous active-low reset.
- p_req_valid  in  NUM_PORTS  per-port request valid.
- p_req_ready  out  NUM_PORTS  per-port request accepted (one-hot or zero).
- p_req_rnw  in  NUM_PORTS  1=read, 0=write.
- p_req_addr  in  NUM_PORTS*ADDR_W  flattened addresses, port 0 in LSBs.
- p_req_be  in  NUM_PORTS*BE_W  write byte enables.
- p_req_wdata  in  NUM_PORTS*DATA_W  write data (single beat, presented with request).
- p_rd_valid  out  NUM_PORTS  read-data valid to owning port.
- p_rd_err  out  NUM_PORTS  read-data error to owning port.
- p_rd_data  out  DATA_W  shared read-data bus.
- mi_mcaddressvalid, mi_mcreadnotwrite, mi_mcwritedatavalid  out  1  controller command strobes.
- mi_mcaddress  out  ADDR_W; mi_mcbyteenable  out  BE_W; mi_mcwritedata  out  DATA_W.
- mi_mcbankconflict, mi_mcrowconflict  out  1  conflict hints.
- mc_miaddrreadytoaccept  in  1  controller accepts command this cycle.
- mc_mireaddata  in  DATA_W; mc_mireaddatavalid  in  1; mc_mireaddataerr  in  1.

Behaviour:
- Reset values: all outputs 0, RR pointer = port 0, FSM = ARB, tag FIFO empty.
- FSM ARB: eligible = p_req_valid, with reads masked when tag FIFO is full. Grant the first eligible port at or after the RR pointer.
  - Grant: pulse p_req_ready[g] for one cycle, capture payload into the output register, and go to HOLD next cycle.
  - RR pointer = g+1, wrapping NUM_PORTS-1 -> 0.
  - No eligible port: stay in ARB.
- FSM HOLD: mi_mcaddressvalid=1, payload stable.
  - mi_mcwritedatavalid = ~rnw, asserted in the same cycles as addressvalid.
  - On mc_miaddrreadytoaccept=1: drop strobes next cycle and return to ARB. If the command was a read, push g into the tag FIFO that cycle.
  - Accept-to-next-issue minimum is 2 cycles (ARB, then HOLD).
- Latency: request valid to mi_mcaddressvalid = 1 cycle when the arbiter is idle.
- Read return: on mc_mireaddatavalid, pop the tag FIFO head h.
  - Next cycle: p_rd_valid[h]=1, p_rd_err[h]=mc_mireaddataerr, p_rd_data=mc_mireaddata (one registered stage).
- Simultaneous push and pop: both occur; count unchanged.
- Read data arriving with the tag FIFO empty: data dropped; sticky internal error flag set (assertion target).
- Tag FIFO full: read requests stall at the arbiter; writes still arbitrated.
- Reset mid-transaction: all state cleared immediately. Outstanding controller reads are the system's responsibility (the controller is reset together).
- Without the optional feature: mi_mcbankconflict = mi_mcrowconflict = 0.

Optional Feature:
- Macro: MIB_ARB_CONFLICT_HINT_EN.
- When defined: 4-entry open-row table (valid + 13-bit row per bank) updated on each accepted command.
  - In HOLD: mi_mcbankconflict=1 if the bank entry is valid and its row differs.
  - mi_mcrowconflict=1 if the bank entry is valid and its row is equal.
  - Table cleared by reset.
- When undefined: no table; both hints tied 0.

Decomposition:
- Package mib_arb_pkg:
  - FSM state enum (ARB, HOLD).
  - Function clog2 and localparam TAG_AW.
  - Typedef for the request payload struct (rnw, addr, be, wdata).
- Sub-module mib_tag_fifo: synchronous FIFO of port IDs (width clog2(NUM_PORTS), depth TAG_DEPTH), with full, empty, push, pop and simultaneous push/pop.

Test Plan:
- Single port 0 write, addr 0x000001000, be 0xFFFF, ready held 1 -> p_req_ready[0] in cycle 1; mi_mcaddressvalid and mi_mcwritedatavalid high cycle 2; no tag pushed.
- Ports 0 and 1 both requesting continuously, ready 1 -> grants alternate 0,1,0,1; fairness count equal after 20 grants.
- Accept backpressure: ready held 0 for 5 cycles -> address, be and data stable for 6 cycles; no second grant until accept.
- 3 reads from ports 1,0,1 -> read data D0,D1,D2 returned to p_rd_valid bit patterns 0b10, 0b01, 0b10 in order; err on D1 routes to p_rd_err[0].
- TAG_DEPTH=8: 8 outstanding reads with no return -> 9th read not granted while a pending write is granted; one return unblocks the read next arbitration.
- With MIB_ARB_CONFLICT_HINT_EN: read bank 1 row 5, then bank 1 row 7 -> bankconflict=1 on the second; then bank 1 row 7 again -> rowconflict=1.
